meta_predictor_ctrl: RTL and testbench

Controller for the tournament-predictor chooser (meta) table, which is a single-port, 2-bit-per-entry array with synchronous read.
- Initialises every entry to weakly-local (2'b01) with a post-reset sweep.
- Arbitrates the single table port between fetch-stage lookups and resolved-branch updates.
- Buffers updates in a small FIFO and performs each update as a read-modify-write saturating-counter step.

---
 rtl/meta_predictor_ctrl.sv | 171 +++++++++++++++++
 tb/tb_meta_predictor_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/meta_predictor_ctrl.sv
// Chooser (meta) table controller: post-reset init sweep, lookup/update arbitration
// of the single table port, and a FIFO of read-modify-write saturating updates.
//
// state  | meaning
// INIT   | sweeping every entry to weakly-local (2'b01)
// IDLE   | serving lookups; start an update when no lookup is taken
// UPD_RD | reading the entry at the FIFO head
// UPD_WR | computing the new counter; write goes out next cycle, head popped
module meta_predictor_ctrl #(
    parameter int IDX_W      = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lookup_valid,
    input  logic [IDX_W-1:0] lookup_idx,
    output logic             lookup_ready,
    output logic             pred_valid,
    output logic [IDX_W-1:0] pred_idx,
    output logic             pred_use_global,
    input  logic             upd_valid,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_global_correct,
    input  logic             upd_local_correct,
    output logic             upd_ready,
    output logic             init_done,
    output logic [IDX_W-1:0] tbl_addr,
    output logic             tbl_re,
    output logic             tbl_we,
    output logic [1:0]       tbl_wdata,
    input  logic [1:0]       tbl_rdata
);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {INIT, IDLE, UPD_RD, UPD_WR} state_t;

    state_t           state, state_nxt;
    logic [IDX_W:0]   sweep_cnt;
    logic             re_nxt, we_nxt, lk_nxt;
    logic [IDX_W-1:0] addr_nxt;
    logic [1:0]       wdata_nxt;
    logic [1:0]       upd_new;

    logic [IDX_W-1:0] q_idx [FIFO_DEPTH];
    logic             q_g   [FIFO_DEPTH];
    logic             q_l   [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [PW:0]      occ;
    logic             full, empty, push, pop, lookup_acc;

    // lookup pipeline: rd_* aligned with tbl_re, dat_* aligned with tbl_rdata
    logic             rd_lk, dat_lk;
    logic [IDX_W-1:0] dat_idx;

    assign full         = (occ == (PW+1)'(FIFO_DEPTH));
    assign empty        = (occ == '0);
    assign lookup_ready = (state == IDLE) && !full;
    assign upd_ready    = init_done && !full;
    assign lookup_acc   = lookup_valid && lookup_ready;
    assign push         = upd_valid && upd_ready;
    assign pop          = (state == UPD_WR);

    always_comb begin
        upd_new = tbl_rdata;
        if (q_g[rd_ptr] && !q_l[rd_ptr]) begin
            upd_new = (tbl_rdata == 2'b11) ? 2'b11 : tbl_rdata + 2'b01;
        end else if (q_l[rd_ptr] && !q_g[rd_ptr]) begin
            upd_new = (tbl_rdata == 2'b00) ? 2'b00 : tbl_rdata - 2'b01;
        end
    end

    // Table-port outputs are registered, so this decodes what drives next cycle.
    always_comb begin
        state_nxt = state;
        re_nxt    = 1'b0;
        we_nxt    = 1'b0;
        lk_nxt    = 1'b0;
        addr_nxt  = '0;
        wdata_nxt = 2'b00;
        case (state)
            INIT: begin
                if (sweep_cnt[IDX_W]) begin
                    state_nxt = IDLE;
                end else begin
                    we_nxt    = 1'b1;
                    addr_nxt  = sweep_cnt[IDX_W-1:0];
                    wdata_nxt = 2'b01;
                end
            end
            IDLE: begin
                if (lookup_acc) begin
                    re_nxt   = 1'b1;
                    lk_nxt   = 1'b1;
                    addr_nxt = lookup_idx;
                end else if (!empty) begin
                    state_nxt = UPD_RD;
                    re_nxt    = 1'b1;
                    addr_nxt  = q_idx[rd_ptr];
                end
            end
            UPD_RD: state_nxt = UPD_WR;
            UPD_WR: begin
                state_nxt = IDLE;
                we_nxt    = 1'b1;
                addr_nxt  = q_idx[rd_ptr];
                wdata_nxt = upd_new;
            end
            default: state_nxt = INIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= INIT;
            sweep_cnt       <= '0;
            init_done       <= 1'b0;
            tbl_re          <= 1'b0;
            tbl_we          <= 1'b0;
            tbl_addr        <= '0;
            tbl_wdata       <= 2'b00;
            rd_lk           <= 1'b0;
            dat_lk          <= 1'b0;
            dat_idx         <= '0;
            pred_valid      <= 1'b0;
            pred_idx        <= '0;
            pred_use_global <= 1'b0;
        end else begin
            state     <= state_nxt;
            tbl_re    <= re_nxt;
            tbl_we    <= we_nxt;
            tbl_addr  <= addr_nxt;
            tbl_wdata <= wdata_nxt;
            rd_lk     <= lk_nxt;
            dat_lk    <= rd_lk;
            dat_idx   <= tbl_addr;
            if (state == INIT) begin
                if (sweep_cnt[IDX_W]) begin
                    init_done <= 1'b1;
                end else begin
                    sweep_cnt <= sweep_cnt + (IDX_W+1)'(1);
                end
            end
            pred_valid <= dat_lk;
            if (dat_lk) begin
                pred_idx        <= dat_idx;
                pred_use_global <= tbl_rdata[1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      occ <= occ + (PW+1)'(1);
            else if (pop && !push) occ <= occ - (PW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_idx[wr_ptr] <= upd_idx;
            q_g[wr_ptr]   <= upd_global_correct;
            q_l[wr_ptr]   <= upd_local_correct;
        end
    end
endmodule

// File: tb/tb_meta_predictor_ctrl.sv
// Directed bench for meta_predictor_ctrl with a behavioural synchronous-read table.
module tb_meta_predictor_ctrl;
    localparam int IDX_W = 10;
    localparam int N     = 1 << IDX_W;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             lookup_valid = 1'b0;
    logic [IDX_W-1:0] lookup_idx = '0;
    logic             lookup_ready;
    logic             pred_valid;
    logic [IDX_W-1:0] pred_idx;
    logic             pred_use_global;
    logic             upd_valid = 1'b0;
    logic [IDX_W-1:0] upd_idx = '0;
    logic             upd_global_correct = 1'b0;
    logic             upd_local_correct = 1'b0;
    logic             upd_ready;
    logic             init_done;
    logic [IDX_W-1:0] tbl_addr;
    logic             tbl_re;
    logic             tbl_we;
    logic [1:0]       tbl_wdata;
    logic [1:0]       tbl_rdata = 2'b00;

    logic [1:0] mem [N];
    int n_vec = 0;
    int n_err = 0;
    int excl_err = 0;

    meta_predictor_ctrl #(.IDX_W(IDX_W), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .lookup_valid(lookup_valid), .lookup_idx(lookup_idx), .lookup_ready(lookup_ready),
        .pred_valid(pred_valid), .pred_idx(pred_idx), .pred_use_global(pred_use_global),
        .upd_valid(upd_valid), .upd_idx(upd_idx),
        .upd_global_correct(upd_global_correct), .upd_local_correct(upd_local_correct),
        .upd_ready(upd_ready), .init_done(init_done),
        .tbl_addr(tbl_addr), .tbl_re(tbl_re), .tbl_we(tbl_we),
        .tbl_wdata(tbl_wdata), .tbl_rdata(tbl_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (tbl_we) mem[tbl_addr] <= tbl_wdata;
        if (tbl_re) tbl_rdata <= mem[tbl_addr];
    end

    always @(negedge clk) begin
        if (!rst && tbl_re && tbl_we) excl_err++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_lookup(input logic [IDX_W-1:0] idx, input logic exp_ug);
        lookup_valid = 1'b1;
        lookup_idx   = idx;
        chk("lookup_ready_idle", 32'(lookup_ready), 32'd1);
        @(negedge clk);
        lookup_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pred_valid", 32'(pred_valid), 32'd1);
        chk("pred_idx", 32'(pred_idx), 32'(idx));
        chk("pred_use_global", 32'(pred_use_global), 32'(exp_ug));
        @(negedge clk);
        chk("pred_pulse_end", 32'(pred_valid), 32'd0);
    endtask

    task automatic do_update(input logic [IDX_W-1:0] idx, input logic g, input logic l,
                             input logic [1:0] exp_entry);
        upd_valid          = 1'b1;
        upd_idx            = idx;
        upd_global_correct = g;
        upd_local_correct  = l;
        chk("upd_ready", 32'(upd_ready), 32'd1);
        @(negedge clk);
        upd_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("entry_after_update", 32'(mem[idx]), 32'(exp_entry));
    endtask

    task automatic push_upd(input logic [IDX_W-1:0] idx, input logic g, input logic l);
        upd_valid          = 1'b1;
        upd_idx            = idx;
        upd_global_correct = g;
        upd_local_correct  = l;
        chk("upd_ready_push", 32'(upd_ready), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        int bad;
        for (int i = 0; i < N; i++) mem[i] = 2'b10;

        repeat (3) @(negedge clk);
        chk("rst_tbl_we", 32'(tbl_we), 32'd0);
        chk("rst_tbl_re", 32'(tbl_re), 32'd0);
        chk("rst_tbl_addr", 32'(tbl_addr), 32'd0);
        chk("rst_tbl_wdata", 32'(tbl_wdata), 32'd0);
        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_lookup_ready", 32'(lookup_ready), 32'd0);
        chk("rst_upd_ready", 32'(upd_ready), 32'd0);
        chk("rst_pred_valid", 32'(pred_valid), 32'd0);

        // Partial sweep, then reset mid-sweep
        rst = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            chk("sweep1_we", 32'(tbl_we), 32'd1);
            chk("sweep1_addr", 32'(tbl_addr), 32'(i));
            chk("sweep1_lookup_ready", 32'(lookup_ready), 32'd0);
        end
        rst = 1'b1;
        #1;
        chk("midrst_we", 32'(tbl_we), 32'd0);
        chk("midrst_addr", 32'(tbl_addr), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            chk("sweep_we", 32'(tbl_we), 32'd1);
            chk("sweep_addr", 32'(tbl_addr), 32'(i));
            chk("sweep_wdata", 32'(tbl_wdata), 32'd1);
            chk("sweep_init_done", 32'(init_done), 32'd0);
            chk("sweep_upd_ready", 32'(upd_ready), 32'd0);
        end
        @(negedge clk);
        chk("post_sweep_we", 32'(tbl_we), 32'd0);
        chk("init_done_rise", 32'(init_done), 32'd1);
        chk("post_lookup_ready", 32'(lookup_ready), 32'd1);
        chk("post_upd_ready", 32'(upd_ready), 32'd1);
        bad = 0;
        for (int i = 0; i < N; i++) if (mem[i] !== 2'b01) bad++;
        chk("sweep_all_weak_local", 32'(bad), 32'd0);

        do_lookup(10'd5, 1'b0);

        do_update(10'd5, 1'b1, 1'b0, 2'b10);
        do_update(10'd5, 1'b1, 1'b0, 2'b11);
        do_lookup(10'd5, 1'b1);
        do_update(10'd5, 1'b1, 1'b0, 2'b11);

        do_update(10'd7, 1'b0, 1'b1, 2'b00);
        do_update(10'd7, 1'b0, 1'b1, 2'b00);
        do_update(10'd7, 1'b0, 1'b1, 2'b00);
        do_update(10'd7, 1'b1, 1'b1, 2'b00);
        do_update(10'd6, 1'b0, 1'b0, 2'b01);
        do_lookup(10'd7, 1'b0);

        // FIFO fills while lookups hog the port
        lookup_valid = 1'b1;
        lookup_idx   = 10'd9;
        push_upd(10'd20, 1'b1, 1'b0);
        push_upd(10'd21, 1'b0, 1'b1);
        push_upd(10'd20, 1'b1, 1'b0);
        push_upd(10'd22, 1'b1, 1'b0);
        upd_valid = 1'b0;
        chk("full_upd_ready", 32'(upd_ready), 32'd0);
        chk("full_lookup_ready", 32'(lookup_ready), 32'd0);
        @(negedge clk);
        chk("upd_rd_lookup_ready", 32'(lookup_ready), 32'd0);
        @(negedge clk);
        chk("upd_wr_lookup_ready", 32'(lookup_ready), 32'd0);
        @(negedge clk);
        chk("resume_lookup_ready", 32'(lookup_ready), 32'd1);
        chk("resume_upd_ready", 32'(upd_ready), 32'd1);
        lookup_valid = 1'b0;
        repeat (20) @(negedge clk);
        chk("full_entry20", 32'(mem[20]), 32'd3);
        chk("full_entry21", 32'(mem[21]), 32'd0);
        chk("full_entry22", 32'(mem[22]), 32'd2);

        // Enqueue in the same cycle as a pop at occupancy 3
        lookup_valid = 1'b1;
        push_upd(10'd30, 1'b0, 1'b1);
        push_upd(10'd30, 1'b0, 1'b1);
        push_upd(10'd30, 1'b1, 1'b0);
        upd_valid    = 1'b0;
        lookup_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("wr_cycle_lookup_ready", 32'(lookup_ready), 32'd0);
        push_upd(10'd30, 1'b1, 1'b0);
        upd_valid = 1'b0;
        chk("occ3_upd_ready", 32'(upd_ready), 32'd1);
        repeat (30) @(negedge clk);
        chk("ordered_entry30", 32'(mem[30]), 32'd2);

        chk("port_exclusive", 32'(excl_err), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
